// File: rtl/frame_writer.sv
// Raster pixel stream to frame RAM writer with a small skid FIFO that absorbs read-port stalls.
// Optional frame counter output enabled by defining FRAME_WRITER_FRAME_CNT_EN.
module frame_writer #(
    parameter int X_W        = 10,
    parameter int Y_W        = 10,
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int PIX_W      = 15,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 pix_valid,
    output logic                 pix_ready,
    input  logic                 pix_sof,
    input  logic [PIX_W-1:0]     pix_data,
    input  logic                 rd_active,
    output logic                 wr_en,
    output logic [X_W+Y_W-1:0]   wr_addr,
    output logic [PIX_W-1:0]     wr_data,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 sync_err
`ifdef FRAME_WRITER_FRAME_CNT_EN
    ,
    output logic [15:0]          frame_count
`endif
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_WAIT_SOF = 2'd1;
    localparam logic [1:0] ST_WRITE    = 2'd2;
    localparam logic [1:0] ST_DONE     = 2'd3;

    localparam int PTR_W     = $clog2(FIFO_DEPTH);
    localparam int FRAME_PIX = H_ACTIVE * V_ACTIVE;
    localparam int CNT_W     = $clog2(FRAME_PIX + 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] acc_cnt;
    logic [X_W-1:0]   x_pos;
    logic [Y_W-1:0]   y_pos;

    logic [PIX_W:0]   fifo_mem [FIFO_DEPTH];
    logic [PTR_W:0]   fifo_wr_ptr;
    logic [PTR_W:0]   fifo_rd_ptr;
    logic             fifo_empty;
    logic             fifo_full;

    logic             xfer;
    logic             push;
    logic             pop;
    logic             pop_sof_p0;
    logic [PIX_W-1:0] pop_data_p0;
    logic [X_W-1:0]   eff_x_p0;
    logic [Y_W-1:0]   eff_y_p0;
    logic             eff_last_p0;

    assign fifo_empty = (fifo_wr_ptr == fifo_rd_ptr);
    assign fifo_full  = (fifo_wr_ptr[PTR_W] != fifo_rd_ptr[PTR_W]) &&
                        (fifo_wr_ptr[PTR_W-1:0] == fifo_rd_ptr[PTR_W-1:0]);

    assign pix_ready = ((state == ST_WAIT_SOF) || (state == ST_WRITE)) &&
                       !fifo_full && (acc_cnt < CNT_W'(FRAME_PIX));
    assign xfer = pix_valid && pix_ready;
    // Non-SOF beats seen while waiting for the frame start are accepted but dropped.
    assign push = xfer && ((state == ST_WRITE) || pix_sof);
    assign pop  = !fifo_empty && !rd_active && (state == ST_WRITE);
    assign busy = (state != ST_IDLE);

    // Stage p0: head of FIFO and its effective address (an SOF beat always lands at 0).
    assign {pop_sof_p0, pop_data_p0} = fifo_mem[fifo_rd_ptr[PTR_W-1:0]];
    assign eff_x_p0    = pop_sof_p0 ? '0 : x_pos;
    assign eff_y_p0    = pop_sof_p0 ? '0 : y_pos;
    assign eff_last_p0 = (eff_x_p0 == X_W'(H_ACTIVE - 1)) && (eff_y_p0 == Y_W'(V_ACTIVE - 1));

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[fifo_wr_ptr[PTR_W-1:0]] <= {pix_sof, pix_data};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fifo_wr_ptr <= '0;
            fifo_rd_ptr <= '0;
        end else begin
            if (push) fifo_wr_ptr <= fifo_wr_ptr + 1'b1;
            if (pop)  fifo_rd_ptr <= fifo_rd_ptr + 1'b1;
        end
    end

    // Stage p1: registered RAM write port and frame bookkeeping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            acc_cnt    <= '0;
            x_pos      <= '0;
            y_pos      <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            frame_done <= 1'b0;
            sync_err   <= 1'b0;
        end else begin
            wr_en      <= pop;
            frame_done <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_WAIT_SOF;
                        sync_err <= 1'b0;
                        acc_cnt  <= '0;
                    end
                end
                ST_WAIT_SOF: begin
                    if (xfer && pix_sof) begin
                        state   <= ST_WRITE;
                        acc_cnt <= CNT_W'(1);
                    end
                end
                ST_WRITE: begin
                    if (xfer) begin
                        acc_cnt <= pix_sof ? CNT_W'(1) : acc_cnt + 1'b1;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase

            if (pop) begin
                wr_addr <= {eff_y_p0, eff_x_p0};
                wr_data <= pop_data_p0;
                if (pop_sof_p0 && ((x_pos != '0) || (y_pos != '0))) begin
                    sync_err <= 1'b1;
                end
                if (eff_x_p0 == X_W'(H_ACTIVE - 1)) begin
                    x_pos <= '0;
                    if (eff_last_p0) begin
                        y_pos      <= '0;
                        state      <= ST_DONE;
                        frame_done <= 1'b1;
                    end else begin
                        y_pos <= eff_y_p0 + 1'b1;
                    end
                end else begin
                    x_pos <= eff_x_p0 + 1'b1;
                    y_pos <= eff_y_p0;
                end
            end
        end
    end

`ifdef FRAME_WRITER_FRAME_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_count <= '0;
        end else if (frame_done) begin
            frame_count <= frame_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_frame_writer.sv
// Randomized bench for frame_writer against a queue-based model of the expected write sequence.
// Also checks frame_count when FRAME_WRITER_FRAME_CNT_EN is defined.
module tb_frame_writer;

    localparam int X_W        = 10;
    localparam int Y_W        = 10;
    localparam int H_ACTIVE   = 4;
    localparam int V_ACTIVE   = 3;
    localparam int PIX_W      = 15;
    localparam int FIFO_DEPTH = 4;
    localparam int NPIX       = H_ACTIVE * V_ACTIVE;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic                 pix_valid;
    logic                 pix_ready;
    logic                 pix_sof;
    logic [PIX_W-1:0]     pix_data;
    logic                 rd_active;
    logic                 wr_en;
    logic [X_W+Y_W-1:0]   wr_addr;
    logic [PIX_W-1:0]     wr_data;
    logic                 busy;
    logic                 frame_done;
    logic                 sync_err;
`ifdef FRAME_WRITER_FRAME_CNT_EN
    logic [15:0]          frame_count;
`endif

    frame_writer #(
        .X_W(X_W), .Y_W(Y_W), .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE),
        .PIX_W(PIX_W), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_sof(pix_sof), .pix_data(pix_data),
        .rd_active(rd_active),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .frame_done(frame_done), .sync_err(sync_err)
`ifdef FRAME_WRITER_FRAME_CNT_EN
        , .frame_count(frame_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [X_W+Y_W-1:0] addr;
        logic [PIX_W-1:0]   data;
        logic               last;
        logic               resync;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;
    int   phase = 0;      // 0 idle, 1 waiting for sof, 2 writing
    int   pos = 0;        // linear raster position of the next beat
    int   acc = 0;
    int   frames = 0;
    bit   exp_sync = 0;
    bit   prev_rd = 0;
    bit   rd_rand = 0;
    int   nxt;
    bit   rdy_last;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Model: turns each accepted beat into the write it must eventually cause.
    always @(negedge clk) begin
        if (!rst) begin
            exp_q.delete();
            phase    = 0;
            pos      = 0;
            acc      = 0;
            frames   = 0;
            exp_sync = 0;
            prev_rd  = 0;
        end else begin
            if (wr_en) begin
                chk("wr_after_rd", 32'(prev_rd), 0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_wr", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("wr_addr", 32'(wr_addr), 32'(mon_e.addr));
                    chk("wr_data", 32'(wr_data), 32'(mon_e.data));
                    chk("frame_done", 32'(frame_done), 32'(mon_e.last));
                    if (mon_e.resync) exp_sync = 1;
                    if (mon_e.last) begin
                        phase = 0;
                        frames++;
                    end
                end
            end else begin
                chk("frame_done_idle", 32'(frame_done), 0);
            end
            chk("sync_err", 32'(sync_err), 32'(exp_sync));
            if (phase == 0 || acc >= NPIX) chk("ready_off", 32'(pix_ready), 0);

            if (phase == 0 && start) begin
                phase    = 1;
                pos      = 0;
                acc      = 0;
                exp_sync = 0;
            end else if (phase != 0 && pix_valid && pix_ready && (phase == 2 || pix_sof)) begin
                phase = 2;
                acc   = pix_sof ? 1 : acc + 1;
                mon_e.resync = pix_sof && (pos != 0);
                if (pix_sof) pos = 0;
                mon_e.addr = (X_W+Y_W)'(((pos / H_ACTIVE) << X_W) + (pos % H_ACTIVE));
                mon_e.data = pix_data;
                mon_e.last = (pos == NPIX - 1);
                pos = (pos + 1) % NPIX;
                exp_q.push_back(mon_e);
            end
            prev_rd = rd_active;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (rd_rand) rd_active = ($urandom_range(0, 3) == 0);
    endtask

    task automatic send_beat(input bit sof, input logic [PIX_W-1:0] d);
        int guard = 0;
        bit done = 0;
        pix_valid = 1'b1;
        pix_sof   = sof;
        pix_data  = d;
        while (!done) begin
            @(negedge clk);
            if (pix_ready) done = 1;
            step();
            guard++;
            if (!done && guard > 200) begin
                chk("beat_timeout", 0, 1);
                done = 1;
            end
        end
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic finish_frame();
        int guard = 0;
        bit seen = 0;
        rd_rand   = 0;
        rd_active = 1'b0;
        while (!seen && guard < 400) begin
            @(negedge clk);
            if (frame_done) seen = 1;
            guard++;
        end
        if (!seen) chk("frame_done_timeout", 0, 1);
        @(negedge clk);
        chk("end_busy", 32'(busy), 0);
        chk("end_ready", 32'(pix_ready), 0);
        chk("end_pending", 32'(exp_q.size()), 0);
`ifdef FRAME_WRITER_FRAME_CNT_EN
        chk("frame_count", 32'(frame_count), 32'(frames[15:0]));
`endif
        step();
    endtask

    task automatic send_frame(input int n_pre, input int resync_at, input bit seq, input bit gaps);
        int n_beats = (resync_at > 0) ? resync_at + NPIX : NPIX;
        pulse_start();
        for (int i = 0; i < n_pre; i++) send_beat(1'b0, 15'h7FFF);
        for (int i = 0; i < n_beats; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) step();
            send_beat((i == 0) || (i == resync_at), seq ? PIX_W'(i) : PIX_W'($urandom));
        end
        finish_frame();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; pix_valid = 1'b0; pix_sof = 1'b0;
        pix_data = '0; rd_active = 1'b0;
        #2 rst = 1'b0;
        #2;
        chk("rst_ready", 32'(pix_ready), 0);
        chk("rst_wr_en", 32'(wr_en), 0);
        chk("rst_wr_addr", 32'(wr_addr), 0);
        chk("rst_wr_data", 32'(wr_data), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_frame_done", 32'(frame_done), 0);
        chk("rst_sync_err", 32'(sync_err), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        step();
        chk("idle_busy", 32'(busy), 0);

        // Plain back-to-back frame, then one with discarded beats before the sof.
        send_frame(0, 0, 1'b1, 1'b0);
        send_frame(3, 0, 1'b1, 1'b0);

        // Read-port stall mid-frame with the source held valid.
        pulse_start();
        for (int i = 0; i < 5; i++) send_beat(i == 0, PIX_W'(i));
        rd_active = 1'b1;
        nxt = 5;
        rdy_last = 1'b1;
        pix_valid = 1'b1;
        pix_sof = 1'b0;
        for (int c = 0; c < 10; c++) begin
            pix_data = PIX_W'(nxt);
            @(negedge clk);
            rdy_last = pix_ready;
            if (pix_ready) nxt++;
            step();
        end
        pix_valid = 1'b0;
        chk("stall_ready_low", 32'(rdy_last), 0);
        chk("stall_accepts_le_depth", 32'((nxt - 5) <= FIFO_DEPTH), 1);
        rd_active = 1'b0;
        while (nxt < NPIX) begin
            send_beat(1'b0, PIX_W'(nxt));
            nxt++;
        end
        finish_frame();

        // Resync on beat 6: sticky error, cleared by the next start.
        send_frame(0, 6, 1'b1, 1'b0);
        chk("sync_sticky", 32'(sync_err), 1);
        step();
        step();
        chk("sync_sticky_idle", 32'(sync_err), 1);
        send_frame(0, 0, 1'b1, 1'b0);
        chk("sync_cleared", 32'(sync_err), 0);

        // Asynchronous reset with two beats parked in the FIFO.
        pulse_start();
        rd_active = 1'b1;
        send_beat(1'b1, 15'h1234);
        send_beat(1'b0, 15'h2345);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(pix_ready), 0);
        chk("mid_rst_wr_en", 32'(wr_en), 0);
        chk("mid_rst_wr_addr", 32'(wr_addr), 0);
        chk("mid_rst_wr_data", 32'(wr_data), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_frame_done", 32'(frame_done), 0);
        chk("mid_rst_sync_err", 32'(sync_err), 0);
        rd_active = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        step();
        chk("post_rst_busy", 32'(busy), 0);
        send_frame(0, 0, 1'b0, 1'b0);

        // Random traffic: gaps, read-port contention, optional resync.
        for (int f = 0; f < 6; f++) begin
            rd_rand = 1;
            send_frame($urandom_range(0, 2),
                       ($urandom_range(0, 2) == 0) ? $urandom_range(1, NPIX - 1) : 0,
                       1'b0, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
